keypad_ctrl: RTL and testbench

Front-panel controller for the microwave: scans and debounces the raw keypad and door switch, encodes digit keys to BCD, and drives the countdown timer's load/clear/enable interface. It writes digits into the timer (data/loadn), issues timer clears, and generates the once-per-second count-enable strobe while cooking. It reads the timer's zero flag to end the cook cycle. At top level, the timer's clrn is clrn AND tclrn; that gating is outside this block.

---
 rtl/microwave_pkg.sv | 38 +++
 rtl/key_debounce.sv | 51 +++++
 rtl/keypad_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_keypad_ctrl.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/microwave_pkg.sv
// Shared definitions for the microwave front panel: FSM state encodings,
// key-vector bit positions and the one-hot digit to BCD encoder.
package microwave_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ENTRY = 3'd1,
        COOK  = 3'd2,
        PAUSE = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam int NUM_KEYS  = 13;
    localparam int KEY_D0    = 0;
    localparam int KEY_D1    = 1;
    localparam int KEY_D2    = 2;
    localparam int KEY_D3    = 3;
    localparam int KEY_D4    = 4;
    localparam int KEY_D5    = 5;
    localparam int KEY_D6    = 6;
    localparam int KEY_D7    = 7;
    localparam int KEY_D8    = 8;
    localparam int KEY_D9    = 9;
    localparam int KEY_START = 10;
    localparam int KEY_STOP  = 11;
    localparam int KEY_CLEAR = 12;

    // Callers guarantee a single bit is set; the highest set bit wins otherwise.
    function automatic logic [3:0] digit_encode(input logic [9:0] digits);
        logic [3:0] code;
        code = 4'd0;
        for (int i = 0; i < 10; i++) begin
            if (digits[i]) code = 4'(i);
        end
        return code;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Two-flop synchronizer, stability counter and press-edge detector for a
// vector of raw push buttons. press is high for one cycle per accepted press.
module key_debounce #(
    parameter int WIDTH           = 13,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic             clock,
    input  logic             clrn,
    input  logic [WIDTH-1:0] raw,
    output logic [WIDTH-1:0] press
);

    localparam int            CW      = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);

    logic [WIDTH-1:0] meta_reg;
    logic [WIDTH-1:0] sync_reg;
    logic [WIDTH-1:0] last_reg;
    logic [WIDTH-1:0] stable_reg;
    logic [CW-1:0]    cnt_reg;
    logic             changed;
    logic             settled;

    // settled: the synchronized vector has held for DEBOUNCE_CYCLES+1 samples
    assign changed = (sync_reg != last_reg);
    assign settled = !changed && (cnt_reg == CNT_MAX);
    assign press   = settled ? (sync_reg & ~stable_reg) : '0;

    always_ff @(posedge clock or negedge clrn) begin
        if (!clrn) begin
            meta_reg   <= '0;
            sync_reg   <= '0;
            last_reg   <= '0;
            stable_reg <= '0;
            cnt_reg    <= '0;
        end else begin
            meta_reg <= raw;
            sync_reg <= meta_reg;
            last_reg <= sync_reg;
            if (changed) begin
                cnt_reg <= CW'(1);
            end else if (cnt_reg != CNT_MAX) begin
                cnt_reg <= cnt_reg + 1'b1;
            end
            if (settled) begin
                stable_reg <= sync_reg;
            end
        end
    end

endmodule

// File: rtl/keypad_ctrl.sv
// Microwave front-panel controller: digit entry into the countdown timer,
// cook/pause/done sequencing and the once-per-second count-enable strobe.
module keypad_ctrl
    import microwave_pkg::*;
#(
    parameter int CLK_PER_SEC     = 1000,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int MAX_DIGITS      = 3
) (
    input  logic       clock,
    input  logic       clrn,
    input  logic [9:0] keys,
    input  logic       start,
    input  logic       stop,
    input  logic       clear,
    input  logic       door_closed,
    input  logic       timer_zero,
    output logic [3:0] data,
    output logic       loadn,
    output logic       tclrn,
    output logic       en,
    output logic       heat,
    output logic       done,
    output logic [2:0] state
);

    localparam int            TW        = $clog2(CLK_PER_SEC);
    localparam int            NW        = $clog2(MAX_DIGITS + 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(CLK_PER_SEC - 1);
    localparam logic [NW-1:0] COUNT_MAX = NW'(MAX_DIGITS);

    logic [NUM_KEYS-1:0] raw_vec;
    logic [NUM_KEYS-1:0] press;
    logic                door_meta_reg;
    logic                door_reg;

    state_t        state_reg, state_next;
    logic [NW-1:0] count_reg, count_next;
    logic [TW-1:0] tick_reg, tick_next;
    logic [3:0]    data_reg, data_next;
    logic          loadn_reg, loadn_next;
    logic          tclrn_reg, tclrn_next;
    logic          en_reg, en_next;
    logic          heat_reg;
    logic          done_reg;

    logic [9:0] ev_digits;
    logic       ev_digit;
    logic       ev_start;
    logic       ev_stop;
    logic       ev_clear;

    assign raw_vec = {clear, stop, start, keys};

    key_debounce #(
        .WIDTH           (NUM_KEYS),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
        .clock (clock),
        .clrn  (clrn),
        .raw   (raw_vec),
        .press (press)
    );

    // Simultaneous digit presses are ambiguous, so only a lone digit counts.
    assign ev_digits = press[KEY_D9:KEY_D0];
    assign ev_digit  = $onehot(ev_digits);
    assign ev_start  = press[KEY_START];
    assign ev_stop   = press[KEY_STOP];
    assign ev_clear  = press[KEY_CLEAR];

    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        tick_next  = tick_reg;
        data_next  = data_reg;
        loadn_next = 1'b1;
        tclrn_next = 1'b1;
        en_next    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (ev_clear || ev_stop || ev_start) begin
                    tclrn_next = 1'b0;
                end else if (ev_digit) begin
                    data_next  = digit_encode(ev_digits);
                    loadn_next = 1'b0;
                    count_next = NW'(1);
                    state_next = ENTRY;
                end
            end
            ENTRY: begin
                if (ev_clear || ev_stop) begin
                    tclrn_next = 1'b0;
                    count_next = '0;
                    state_next = IDLE;
                end else if (ev_start) begin
                    if (door_reg && !timer_zero) begin
                        tick_next  = '0;
                        state_next = COOK;
                    end
                end else if (ev_digit && (count_reg < COUNT_MAX)) begin
                    data_next  = digit_encode(ev_digits);
                    loadn_next = 1'b0;
                    count_next = count_reg + 1'b1;
                end
            end
            COOK: begin
                // The tick only advances on cycles that stay in COOK, so a
                // pause freezes it exactly where the interruption landed.
                if (ev_clear) begin
                    tclrn_next = 1'b0;
                    count_next = '0;
                    state_next = IDLE;
                end else if (timer_zero) begin
                    state_next = DONE;
                end else if (ev_stop || !door_reg) begin
                    state_next = PAUSE;
                end else if (tick_reg == TICK_LAST) begin
                    tick_next = '0;
                    en_next   = 1'b1;
                end else begin
                    tick_next = tick_reg + 1'b1;
                end
            end
            PAUSE: begin
                if (ev_clear || ev_stop) begin
                    tclrn_next = 1'b0;
                    count_next = '0;
                    state_next = IDLE;
                end else if (ev_start && door_reg) begin
                    state_next = COOK;
                end
            end
            DONE: begin
                if (|press) begin
                    count_next = '0;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge clrn) begin
        if (!clrn) begin
            door_meta_reg <= 1'b0;
            door_reg      <= 1'b0;
            state_reg     <= IDLE;
            count_reg     <= '0;
            tick_reg      <= '0;
            data_reg      <= 4'd0;
            loadn_reg     <= 1'b1;
            tclrn_reg     <= 1'b1;
            en_reg        <= 1'b0;
            heat_reg      <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            door_meta_reg <= door_closed;
            door_reg      <= door_meta_reg;
            state_reg     <= state_next;
            count_reg     <= count_next;
            tick_reg      <= tick_next;
            data_reg      <= data_next;
            loadn_reg     <= loadn_next;
            tclrn_reg     <= tclrn_next;
            en_reg        <= en_next;
            heat_reg      <= (state_next == COOK);
            done_reg      <= (state_next == DONE);
        end
    end

    assign data  = data_reg;
    assign loadn = loadn_reg;
    assign tclrn = tclrn_reg;
    assign en    = en_reg;
    assign heat  = heat_reg;
    assign done  = done_reg;
    assign state = state_reg;

endmodule

// File: tb/tb_keypad_ctrl.sv
// Bench for keypad_ctrl: a per-cycle reference model of the front panel plus
// a decimal countdown timer that closes the loop through timer_zero.
module tb_keypad_ctrl;

    localparam int CPS  = 20;
    localparam int DEB  = 4;
    localparam int MAXD = 3;

    localparam logic [12:0] K_START = 13'h0400;
    localparam logic [12:0] K_STOP  = 13'h0800;
    localparam logic [12:0] K_CLEAR = 13'h1000;

    logic       clock = 1'b0;
    logic       clrn = 1'b0;
    logic [9:0] keys = '0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       clear = 1'b0;
    logic       door_closed = 1'b1;
    logic       timer_zero = 1'b1;
    logic [3:0] data;
    logic       loadn;
    logic       tclrn;
    logic       en;
    logic       heat;
    logic       done;
    logic [2:0] state;

    keypad_ctrl #(
        .CLK_PER_SEC     (CPS),
        .DEBOUNCE_CYCLES (DEB),
        .MAX_DIGITS      (MAXD)
    ) dut (
        .clock       (clock),
        .clrn        (clrn),
        .keys        (keys),
        .start       (start),
        .stop        (stop),
        .clear       (clear),
        .door_closed (door_closed),
        .timer_zero  (timer_zero),
        .data        (data),
        .loadn       (loadn),
        .tclrn       (tclrn),
        .en          (en),
        .heat        (heat),
        .done        (done),
        .state       (state)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int passed = 0;
    int cyc = 0;
    int tval = 0;

    logic [12:0] rhist[$];
    logic        dhist[$];
    logic [12:0] m_stable;
    int          m_state;
    int          m_count;
    int          m_cook;
    logic [3:0]  m_data;
    logic        m_loadn;
    logic        m_tclrn;
    logic        m_en;

    int   n_load, n_tclr, n_en, cook_entry;
    int   en_cycs[$];
    logic [2:0] prev_st = 3'd0;

    typedef struct {
        logic [12:0] raw;
        logic        door;
        int          exp_state;
        int          exp_loads;
        int          exp_tclrs;
        int          exp_data;
    } vec_t;

    vec_t tbl[11];

    function automatic logic [12:0] dig(input int n);
        return 13'(1) << n;
    endfunction

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    endtask

    task automatic set_raw(input logic [12:0] v);
        {clear, stop, start, keys} = v;
    endtask

    task automatic model_reset();
        rhist.delete();
        dhist.delete();
        for (int i = 0; i < DEB + 3; i++) begin
            rhist.push_back(13'd0);
            dhist.push_back(1'b0);
        end
        m_stable = '0;
        m_state  = 0;
        m_count  = 0;
        m_cook   = 0;
        m_data   = 4'd0;
        m_loadn  = 1'b1;
        m_tclrn  = 1'b1;
        m_en     = 1'b0;
        tval       = 0;
        timer_zero = 1'b1;
    endtask

    // Decimal seconds countdown standing in for the real timer.
    task automatic timer_env(input logic pl, input logic pt, input logic pe, input logic [3:0] pd);
        if (!pt) tval = 0;
        else if (!pl) tval = (tval * 10 + int'(pd)) % 1000;
        else if (pe && tval > 0) tval--;
        timer_zero = (tval == 0);
    endtask

    // A key vector is accepted once the synchronized view (two samples late)
    // has shown the same value for DEB+1 consecutive samples.
    task automatic model_step(input logic [12:0] r, input logic d, input logic tz);
        logic [12:0] ev;
        logic [12:0] v;
        logic [9:0]  dg;
        logic        settled;
        logic        door_s;
        int          nd;
        int          dv;
        rhist.push_front(r);
        void'(rhist.pop_back());
        dhist.push_front(d);
        void'(dhist.pop_back());
        v = rhist[2];
        settled = 1'b1;
        for (int i = 2; i <= 2 + DEB; i++) if (rhist[i] != v) settled = 1'b0;
        ev = '0;
        if (settled) begin
            ev = v & ~m_stable;
            m_stable = v;
        end
        door_s = dhist[2];
        dg = ev[9:0];
        nd = $countones(dg);
        dv = 0;
        for (int i = 0; i < 10; i++) if (dg[i]) dv = i;
        m_loadn = 1'b1;
        m_tclrn = 1'b1;
        m_en    = 1'b0;
        case (m_state)
            0: begin
                if (ev[10] || ev[11] || ev[12]) m_tclrn = 1'b0;
                else if (nd == 1) begin
                    m_data = 4'(dv); m_loadn = 1'b0; m_count = 1; m_state = 1;
                end
            end
            1: begin
                if (ev[12] || ev[11]) begin
                    m_tclrn = 1'b0; m_count = 0; m_state = 0;
                end else if (ev[10]) begin
                    if (door_s && !tz) begin m_state = 2; m_cook = 0; end
                end else if (nd == 1 && m_count < MAXD) begin
                    m_data = 4'(dv); m_loadn = 1'b0; m_count++;
                end
            end
            2: begin
                if (ev[12]) begin
                    m_tclrn = 1'b0; m_count = 0; m_state = 0;
                end else if (tz) m_state = 4;
                else if (ev[11] || !door_s) m_state = 3;
                else begin
                    m_cook++;
                    if (m_cook % CPS == 0) m_en = 1'b1;
                end
            end
            3: begin
                if (ev[12] || ev[11]) begin
                    m_tclrn = 1'b0; m_count = 0; m_state = 0;
                end else if (ev[10] && door_s) m_state = 2;
            end
            default: begin
                if (ev != 0) begin m_state = 0; m_count = 0; end
            end
        endcase
    endtask

    task automatic tick();
        logic [12:0] r;
        logic        d, tz, pl, pt, pe;
        logic [3:0]  pd;
        logic [11:0] got, exp;
        r = {clear, stop, start, keys};
        d = door_closed;
        tz = timer_zero;
        pl = loadn; pt = tclrn; pe = en; pd = data;
        @(posedge clock);
        #1;
        cyc++;
        timer_env(pl, pt, pe, pd);
        model_step(r, d, tz);
        if (!loadn) n_load++;
        if (!tclrn) n_tclr++;
        if (en) begin n_en++; en_cycs.push_back(cyc); end
        if (state == 3'd2 && prev_st != 3'd2) cook_entry = cyc;
        prev_st = state;
        got = {state, data, loadn, tclrn, en, heat, done};
        exp = {3'(m_state), m_data, m_loadn, m_tclrn, m_en, m_state == 2, m_state == 4};
        checks++;
        if (got === exp) passed++;
        else $display("FAIL model cyc %0d: got st=%0d data=%0d loadn=%b tclrn=%b en=%b heat=%b done=%b, expected st=%0d data=%0d loadn=%b tclrn=%b en=%b heat=%b done=%b",
                      cyc, got[11:9], got[8:5], got[4], got[3], got[2], got[1], got[0],
                      exp[11:9], exp[8:5], exp[4], exp[3], exp[2], exp[1], exp[0]);
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic press_keys(input logic [12:0] v, input int hold, input int gap);
        set_raw(v);
        run(hold);
        set_raw('0);
        run(gap);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int guard, lat, got;
        logic [12:0] v;

        tbl[0]  = '{dig(1),            1'b1, 1, 1, 0, 1};
        tbl[1]  = '{dig(3),            1'b1, 1, 1, 0, 3};
        tbl[2]  = '{dig(0),            1'b1, 1, 1, 0, 0};
        tbl[3]  = '{dig(5),            1'b1, 1, 0, 0, 0};
        tbl[4]  = '{K_STOP,            1'b1, 0, 0, 1, 0};
        tbl[5]  = '{dig(2) | dig(4),   1'b1, 0, 0, 0, 0};
        tbl[6]  = '{K_START,           1'b1, 0, 0, 1, 0};
        tbl[7]  = '{dig(9),            1'b1, 1, 1, 0, 9};
        tbl[8]  = '{K_START,           1'b0, 1, 0, 0, 9};
        tbl[9]  = '{dig(2) | dig(4),   1'b1, 1, 0, 0, 9};
        tbl[10] = '{K_CLEAR,           1'b1, 0, 0, 1, 9};

        model_reset();
        #12;
        check("reset outputs", int'({state, data, loadn, tclrn, en, heat, done}), int'(12'b000_0000_11000));
        #11 clrn = 1'b1;

        run(5);
        for (int i = 0; i < 11; i++) begin
            door_closed = tbl[i].door;
            n_load = 0;
            n_tclr = 0;
            press_keys(tbl[i].raw, 10, 10);
            check($sformatf("tbl%0d state", i), int'(state), tbl[i].exp_state);
            check($sformatf("tbl%0d loads", i), n_load, tbl[i].exp_loads);
            check($sformatf("tbl%0d clears", i), n_tclr, tbl[i].exp_tclrs);
            check($sformatf("tbl%0d data", i), int'(data), tbl[i].exp_data);
        end

        // Five-second cook to completion.
        door_closed = 1'b1;
        press_keys(dig(0), 10, 10);
        press_keys(dig(0), 10, 10);
        press_keys(dig(5), 10, 10);
        check("cook5 entry data", int'(data), 5);
        en_cycs.delete();
        n_en = 0;
        press_keys(K_START, 10, 10);
        check("cook5 heat", int'(heat), 1);
        guard = 0;
        while (state != 3'd4 && guard < 300) begin tick(); guard++; end
        check("cook5 reached DONE", int'(state), 4);
        check("cook5 en count", en_cycs.size(), 5);
        if (en_cycs.size() >= 5) begin
            check("cook5 first en delay", en_cycs[0] - cook_entry, CPS);
            check("cook5 en period", en_cycs[4] - en_cycs[3], CPS);
        end
        check("cook5 done/heat", int'({done, heat}), 2);
        run(60);
        check("cook5 no en after done", n_en, 5);
        n_load = 0;
        press_keys(dig(3), 10, 10);
        check("done exit state", int'(state), 0);
        check("done exit no load", n_load, 0);

        // Bouncing key 7, then a clean hold.
        n_load = 0;
        for (int i = 0; i < 40; i++) begin
            keys[7] = ((i / 2) % 2 == 0);
            tick();
        end
        check("bounce no load", n_load, 0);
        keys[7] = 1'b1;
        lat = 0;
        for (int j = 1; j <= 20; j++) begin
            tick();
            if (!loadn && lat == 0) lat = j;
        end
        check("bounce load latency", lat, DEB + 3);
        check("bounce data", int'(data), 7);
        keys = '0;
        run(10);
        check("bounce single load", n_load, 1);
        press_keys(dig(2) | dig(4), 10, 10);
        check("two digits no load", n_load, 1);
        press_keys(K_CLEAR, 10, 10);

        // Door opened mid-second, then resumed.
        press_keys(dig(3), 10, 10);
        press_keys(dig(0), 10, 10);
        set_raw(K_START);
        run(10);
        set_raw('0);
        guard = 0;
        while (!en && guard < 60) begin tick(); guard++; end
        check("pause first en seen", int'(en), 1);
        run(7);
        door_closed = 1'b0;
        got = 0;
        for (int j = 0; j < 3; j++) begin
            tick();
            if (state == 3'd3) got = 1;
        end
        check("pause reached", got, 1);
        check("pause heat", int'(heat), 0);
        n_en = 0;
        run(30);
        check("pause no en", n_en, 0);
        door_closed = 1'b1;
        run(4);
        set_raw(K_START);
        guard = 0;
        while (state != 3'd2 && guard < 20) begin tick(); guard++; end
        check("resume state", int'(state), 2);
        lat = 0;
        while (!en && lat < 40) begin tick(); lat++; end
        check("resume cycles to en", lat, CPS - 9);
        set_raw('0);
        run(8);

        // Clear while cooking, and clear beating start in PAUSE.
        n_tclr = 0;
        press_keys(K_CLEAR, 10, 10);
        check("cook clear pulses", n_tclr, 1);
        check("cook clear state/heat", int'({state, heat}), 0);
        press_keys(dig(9), 10, 10);
        press_keys(K_START, 10, 10);
        press_keys(K_STOP, 10, 10);
        check("stop to pause", int'(state), 3);
        n_tclr = 0;
        press_keys(K_START | K_CLEAR, 10, 10);
        check("start+clear state", int'(state), 0);
        check("start+clear pulses", n_tclr, 1);

        // Asynchronous reset in the middle of a cook.
        press_keys(dig(5), 10, 10);
        press_keys(K_START, 10, 10);
        run(20);
        check("pre-reset cooking", int'(heat), 1);
        #2 clrn = 1'b0;
        #1;
        check("async reset outputs", int'({state, loadn, tclrn, en, heat, done}), int'(8'b000_11000));
        @(posedge clock);
        @(posedge clock);
        #3 clrn = 1'b1;
        model_reset();
        prev_st = 3'd0;
        n_load = 0;
        press_keys(dig(4), 10, 10);
        check("post-reset load", n_load, 1);
        check("post-reset data", int'(data), 4);

        // Randomized traffic against the model.
        for (int s = 0; s < 250; s++) begin
            got = $urandom_range(0, 99);
            if (got < 55) v = dig($urandom_range(0, 9));
            else if (got < 70) v = K_START;
            else if (got < 78) v = K_STOP;
            else if (got < 84) v = K_CLEAR;
            else if (got < 92) v = dig($urandom_range(0, 9)) | dig($urandom_range(0, 9));
            else v = 13'($urandom);
            if ($urandom_range(0, 9) == 0) door_closed = ~door_closed;
            press_keys(v, $urandom_range(1, 12), $urandom_range(1, 15));
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
